// File: rtl/addr4u_sub_checker.sv
// addr4u_sub_checker: recovers operand A as (sum - b) and flags sum != a + b.
// A 2-stage valid/ready pipeline feeds a fault-status FSM and a saturating error counter.
// Ports:
//   clk, rst_n                   : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready, a, b, sum : operand/result triple under check
//   clear_err                    : synchronous clear of the counter and the FSM
//   out_valid/out_ready          : check result handshake
//   out_diff, out_mismatch       : recovered operand and mismatch flag
//   status, err_count            : 0=OK 1=SUSPECT 2=FAULTED; saturating mismatch count
// Latency: 2 cycles from accept to out_valid, 1 result per cycle.
// Backpressure: stage 2 holds while out_valid && !out_ready; stage 1 advances only into a free or draining stage 2.
module addr4u_sub_checker #(
  parameter int ERR_CNT_W    = 8,
  parameter int FAULT_THRESH = 3,
  parameter int RECOVER_CNT  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           a,
  input  logic [3:0]           b,
  input  logic [4:0]           sum,
  input  logic                 clear_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_diff,
  output logic                 out_mismatch,
  output logic [1:0]           status,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULTED = 2'd2
  } state_t;

  localparam logic [3:0]           THRESH_L = 4'(FAULT_THRESH);
  localparam logic [7:0]           RECOV_L  = 8'(RECOVER_CNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  // Stage 1: registered triple
  logic       s1_valid;
  logic [3:0] s1_a;
  logic [3:0] s1_b;
  logic [4:0] s1_sum;

  logic       s2_adv;
  logic       accept;
  logic       hs;
  logic [5:0] diff6;
  logic       mis_c;

  // Stage 2 can take new data when empty or when its result leaves this cycle.
  // in_ready is derived from state and out_ready only, never from in_valid.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;

  // 6-bit subtraction: bit 5 is the borrow. A borrow or any difference from {0,a}
  // is equivalent to sum != a + b over the full 5-bit result.
  assign diff6 = {1'b0, s1_sum} - {2'b00, s1_b};
  assign mis_c = diff6[5] | (diff6[4:0] != {1'b0, s1_a});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sum   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_sum   <= sum;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_diff     <= '0;
      out_mismatch <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_diff     <= diff6[3:0];
        out_mismatch <= mis_c;
      end
    end
  end

  // Fault-status FSM and statistics, advanced only by delivered results
  state_t               state_q, state_d;
  logic [3:0]           bad_q, bad_d;
  logic [7:0]           good_q, good_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OK;
      bad_q   <= '0;
      good_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    good_d  = good_q;
    err_d   = err_q;
    if (clear_err) begin
      // Clear takes priority over a coincident handshake; that result is not counted.
      state_d = ST_OK;
      bad_d   = '0;
      good_d  = '0;
      err_d   = '0;
    end else if (hs) begin
      if (out_mismatch && (err_q != ERR_MAX)) begin
        err_d = err_q + ERR_ONE;
      end
      case (state_q)
        ST_OK: begin
          if (out_mismatch) begin
            bad_d   = 4'd1;
            good_d  = '0;
            state_d = (THRESH_L == 4'd1) ? ST_FAULTED : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (out_mismatch) begin
            // bad_q stays below THRESH_L (<= 15) here, so the increment cannot wrap
            bad_d  = bad_q + 4'd1;
            good_d = '0;
            if ((bad_q + 4'd1) >= THRESH_L) begin
              state_d = ST_FAULTED;
            end
          end else begin
            good_d = good_q + 8'd1;
            bad_d  = '0;
            if ((good_q + 8'd1) >= RECOV_L) begin
              state_d = ST_OK;
              good_d  = '0;
            end
          end
        end
        default: begin
          // FAULTED is sticky until clear_err or reset
        end
      endcase
    end
  end

  assign status    = state_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_addr4u_sub_checker.sv
// Testbench for addr4u_sub_checker: two instances (default and ERR_CNT_W=2/RECOVER_CNT=2)
// share all stimulus and are compared every cycle against a queue-based reference model,
// plus table vectors and hand-written corner-case sequences.
module tb_addr4u_sub_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [4:0] sum;
  logic       clear_err;
  logic       out_ready;

  logic       in_ready_0, out_valid_0, out_mismatch_0;
  logic [3:0] out_diff_0;
  logic [1:0] status_0;
  logic [7:0] err_count_0;

  logic       in_ready_1, out_valid_1, out_mismatch_1;
  logic [3:0] out_diff_1;
  logic [1:0] status_1;
  logic [1:0] err_count_1;

  always #5 clk = ~clk;

  addr4u_sub_checker dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_0),
    .a(a), .b(b), .sum(sum), .clear_err(clear_err),
    .out_valid(out_valid_0), .out_ready(out_ready), .out_diff(out_diff_0),
    .out_mismatch(out_mismatch_0), .status(status_0), .err_count(err_count_0)
  );

  addr4u_sub_checker #(.ERR_CNT_W(2), .FAULT_THRESH(3), .RECOVER_CNT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
    .a(a), .b(b), .sum(sum), .clear_err(clear_err),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_diff(out_diff_1),
    .out_mismatch(out_mismatch_1), .status(status_1), .err_count(err_count_1)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
    logic [3:0] diff;
    logic       mis;
  } vec_t;

  typedef struct {
    logic [3:0] diff;
    logic       mis;
    int         age;
  } item_t;

  vec_t  vecs[10];
  item_t q[$];
  vec_t  cur;
  bit    last_acc;

  // Per-instance reference statistics; index 0 = dut0, 1 = dut1
  int st[2], bad[2], good[2], errc[2];
  int thr[2]  = '{3, 3};
  int rec[2]  = '{16, 2};
  int emax[2] = '{255, 3};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; bad[i] = 0; good[i] = 0; errc[i] = 0;
    end
  endtask

  // Status rules: a mismatch moves toward FAULTED, enough good results return SUSPECT to OK.
  task automatic model_deliver(input bit mis);
    for (int i = 0; i < 2; i++) begin
      if (mis && errc[i] < emax[i]) errc[i]++;
      if (st[i] != 2) begin
        if (mis) begin
          bad[i]  = (st[i] == 0) ? 1 : bad[i] + 1;
          good[i] = 0;
          st[i]   = (bad[i] >= thr[i]) ? 2 : 1;
        end else if (st[i] == 1) begin
          good[i]++;
          bad[i] = 0;
          if (good[i] >= rec[i]) begin
            st[i] = 0;
            good[i] = 0;
          end
        end
      end
    end
  endtask

  // One clock: check everything at the negedge, then advance the model across the posedge.
  task automatic step();
    bit    exp_ov, exp_ir, hs;
    item_t it;
    @(negedge clk);
    exp_ov = (q.size() > 0) && (q[0].age >= 2);
    exp_ir = (q.size() < 2) || out_ready;
    chk("in_ready0", in_ready_0, exp_ir);
    chk("in_ready1", in_ready_1, exp_ir);
    chk("out_valid0", out_valid_0, exp_ov);
    chk("out_valid1", out_valid_1, exp_ov);
    if (exp_ov) begin
      chk("out_diff0", out_diff_0, q[0].diff);
      chk("out_mis0", out_mismatch_0, q[0].mis);
      chk("out_diff1", out_diff_1, q[0].diff);
      chk("out_mis1", out_mismatch_1, q[0].mis);
    end
    chk("status0", status_0, st[0]);
    chk("status1", status_1, st[1]);
    chk("err_count0", err_count_0, errc[0]);
    chk("err_count1", err_count_1, errc[1]);
    last_acc = in_valid && exp_ir;
    hs       = exp_ov && out_ready;
    @(posedge clk);
    if (clear_err) model_clear();
    else if (hs) model_deliver(q[0].mis);
    if (hs) void'(q.pop_front());
    foreach (q[k]) q[k].age++;
    if (last_acc) begin
      it.diff = cur.diff; it.mis = cur.mis; it.age = 1;
      q.push_back(it);
    end
    #1;
  endtask

  task automatic drive_cur();
    a = cur.a; b = cur.b; sum = cur.sum;
  endtask

  task automatic send(input vec_t v);
    bit done = 0;
    cur = v;
    drive_cur();
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      step();
      done = last_acc;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: triple not accepted within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
  endtask

  initial begin
    int   k;
    int   cnt;
    logic [3:0] ra, rb;
    logic [4:0] rs;

    //            a      b      sum     diff   mis
    vecs[0] = '{4'd9,  4'd8,  5'd17, 4'd9,  1'b0};
    vecs[1] = '{4'd15, 4'd15, 5'd30, 4'd15, 1'b0};
    vecs[2] = '{4'd0,  4'd0,  5'd0,  4'd0,  1'b0};
    vecs[3] = '{4'd3,  4'd5,  5'd9,  4'd4,  1'b1};
    vecs[4] = '{4'd1,  4'd2,  5'd4,  4'd2,  1'b1};
    vecs[5] = '{4'd7,  4'd7,  5'd15, 4'd8,  1'b1};
    vecs[6] = '{4'd10, 4'd3,  5'd14, 4'd11, 1'b1};
    vecs[7] = '{4'd2,  4'd2,  5'd4,  4'd2,  1'b0};
    vecs[8] = '{4'd0,  4'd15, 5'd31, 4'd0,  1'b1};
    vecs[9] = '{4'd4,  4'd9,  5'd2,  4'd9,  1'b1};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sum = '0;
    clear_err = 1'b0; out_ready = 1'b1;
    model_clear();
    cur = vecs[0];
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", out_valid_0, 0);
    chk("rst_in_ready", in_ready_0, 1);
    chk("rst_out_diff", out_diff_0, 0);
    chk("rst_out_mis", out_mismatch_0, 0);
    chk("rst_status", status_0, 0);
    chk("rst_err_count", err_count_0, 0);
    rst_n = 1'b1;

    // Single triple: latency of two cycles
    send(vecs[0]);
    #3 chk("t1_no_early_valid", out_valid_0, 0);
    step();
    #3 chk("t1_latency_valid", out_valid_0, 1);
    chk("t1_diff", out_diff_0, 9);
    idle(2);

    // Back-to-back stream
    for (int i = 1; i <= 3; i++) send(vecs[i]);
    idle(3);
    chk("t2_status", status_0, 1);
    chk("t2_err", err_count_0, 1);

    // Three consecutive mismatches then a good one; FAULTED is sticky
    pulse_clear();
    for (int i = 4; i <= 7; i++) send(vecs[i]);
    idle(3);
    chk("t3_status", status_0, 2);
    chk("t3_err", err_count_0, 3);
    pulse_clear();
    chk("t3_clr_status", status_0, 0);
    chk("t3_clr_err", err_count_0, 0);

    // Clear coinciding with a mismatch handshake: the result is not counted
    send(vecs[4]);
    step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clr_hs_err", err_count_0, 0);
    chk("clr_hs_status", status_0, 0);
    idle(2);

    // Backpressure: 6 stalled cycles with in_valid held high
    out_ready = 1'b0;
    in_valid  = 1'b1;
    k = 0; cnt = 0;
    cur = vecs[k]; drive_cur();
    for (int n = 0; n < 6; n++) begin
      step();
      if (last_acc) begin
        cnt++; k++;
        cur = vecs[k]; drive_cur();
      end
    end
    chk("t4_accepted", cnt, 2);
    chk("t4_in_ready_low", in_ready_0, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Saturation and recovery (dut1 has ERR_CNT_W=2, RECOVER_CNT=2)
    pulse_clear();
    send(vecs[4]);
    send(vecs[7]);
    send(vecs[2]);
    idle(3);
    chk("t5_recovered1", status_1, 0);
    chk("t5_suspect0", status_0, 1);
    send(vecs[4]); send(vecs[5]); send(vecs[6]); send(vecs[8]); send(vecs[9]);
    idle(3);
    chk("t5_sat_err1", err_count_1, 3);
    chk("t5_status1", status_1, 2);
    chk("t5_err0", err_count_0, 6);
    chk("t5_status0", status_0, 2);

    // Reset with two results in flight and the output stalled
    pulse_clear();
    out_ready = 1'b0;
    send(vecs[8]);
    send(vecs[9]);
    idle(2);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_ov_async0", out_valid_0, 0);
    chk("t6_ov_async1", out_valid_1, 0);
    q.delete();
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("t6_in_ready", in_ready_0, 1);
    chk("t6_err", err_count_0, 0);
    chk("t6_status", status_0, 0);
    idle(4);

    // Randomized traffic with random backpressure and occasional clears
    for (int n = 0; n < 400; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : ({1'b0, ra} + {1'b0, rb});
      cur.a = ra; cur.b = rb; cur.sum = rs;
      cur.diff = 4'((int'(rs) - int'(rb) + 32) % 16);
      cur.mis  = (int'(rs) != int'(ra) + int'(rb));
      drive_cur();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid = 1'b0; clear_err = 1'b0; out_ready = 1'b1;
    idle(4);
    chk("final_drained", out_valid_0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
